// File: rtl/binocular_pkg.sv
// Shared types and constants for the binocular filter pipeline.
package binocular_pkg;

    localparam int PIX_W = 8;
    localparam int WIN   = 7;

    typedef logic [PIX_W-1:0] pix_t;
    typedef pix_t [WIN-1:0]   col_t;

    // Raster-to-column feeder states.
    typedef logic [1:0] state_t;
    localparam state_t IDLE   = 2'd0;
    localparam state_t FILL   = 2'd1;
    localparam state_t STREAM = 2'd2;

endpackage

// File: rtl/window_column_feeder_line_ram.sv
// One image-line buffer: asynchronous read, synchronous write.
// A read and a write to the same address in one cycle return the old contents.
module line_ram #(
    parameter int DEPTH = 640,
    parameter int WIDTH = 8,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    addr_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem [DEPTH];

    assign rdata_o = mem[addr_i];

    // Contents are deliberately never cleared.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[addr_i] <= wdata_i;
        end
    end

endmodule

// File: rtl/window_column_feeder.sv
// Raster pixel stream to vertical WIN-pixel columns for the guided-filter window.
// Optional build macro WCF_BORDER_REPLICATE_EN: also emit columns while the
// line buffers fill, replicating the frame's top row into missing rows.
module window_column_feeder #(
    parameter int PIX_W = binocular_pkg::PIX_W,
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int WIN   = binocular_pkg::WIN
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [PIX_W-1:0]     in_pix,
    input  logic                 in_valid,
    input  logic                 in_sof,
    output logic                 in_ready,
    output logic [WIN*PIX_W-1:0] out_col,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_sol,
    output logic                 out_eol,
    output logic                 out_eof,
    output logic                 frame_err
);
    import binocular_pkg::*;

    localparam int NLB = WIN - 1;
    localparam int XW  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int YW  = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [XW-1:0] X_LAST   = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST   = YW'(IMG_H - 1);
    localparam logic [YW-1:0] Y_STREAM = YW'(WIN - 1);

    state_t               state_q, state_d;
    logic [XW-1:0]        x_q, x_d;
    logic [YW-1:0]        y_q, y_d;
    logic                 vld_q, vld_d;
    logic [WIN*PIX_W-1:0] col_q, col_d;
    logic                 sol_q, sol_d, eol_q, eol_d, eof_q, eof_d;
    logic                 err_q, err_d;
    logic                 rdy_en_q;

    logic                 accept, start, drop, take, emit, load;
    state_t               cur_state;
    logic [XW-1:0]        cur_x;
    logic [YW-1:0]        cur_y;
    logic [YW-1:0]        y_inc;
    logic [PIX_W-1:0]     rd [NLB];
    logic [PIX_W-1:0]     wr [NLB];
    logic [PIX_W-1:0]     top_pix;
    logic [WIN*PIX_W-1:0] col_new;

    // rdy_en_q holds in_ready low while and just after reset.
    assign in_ready  = rdy_en_q && (!vld_q || out_ready);
    assign out_valid = vld_q;
    assign out_col   = col_q;
    assign out_sol   = sol_q;
    assign out_eol   = eol_q;
    assign out_eof   = eof_q;
    assign frame_err = err_q;

    // Decode the accepted pixel; in_sof always restarts at (0,0) in FILL.
    always_comb begin
        accept    = in_valid && in_ready;
        start     = accept && in_sof;
        drop      = accept && !in_sof && (state_q == IDLE);
        take      = accept && !drop;
        cur_state = start ? FILL : state_q;
        cur_x     = start ? '0 : x_q;
        cur_y     = start ? '0 : y_q;
`ifdef WCF_BORDER_REPLICATE_EN
        emit      = take;
`else
        emit      = take && (cur_state == STREAM);
`endif
        load      = emit;
    end

    // Line buffers form a vertical shift chain: lb0 takes the new pixel.
    always_comb begin
        for (int k = 0; k < NLB; k++) begin
            wr[k] = (k == 0) ? in_pix : rd[(k == 0) ? 0 : k - 1];
        end
    end

    for (genvar g = 0; g < NLB; g++) begin : g_lb
        line_ram #(
            .DEPTH (IMG_W),
            .WIDTH (PIX_W),
            .AW    (XW)
        ) u_lb (
            .clk_i   (clk),
            .we_i    (take),
            .addr_i  (cur_x),
            .wdata_i (wr[g]),
            .rdata_o (rd[g])
        );
    end

    // Assemble the column: oldest row at the bottom slice, current pixel on top.
    always_comb begin
        top_pix = in_pix;
        for (int k = 0; k < NLB; k++) begin
            if (int'(cur_y) == k + 1) begin
                top_pix = rd[k];
            end
        end
        col_new = '0;
        col_new[(WIN-1)*PIX_W +: PIX_W] = in_pix;
        for (int k = 0; k < NLB; k++) begin
            col_new[(WIN-2-k)*PIX_W +: PIX_W] = rd[k];
`ifdef WCF_BORDER_REPLICATE_EN
            // Rows above the frame's first line take the first line's value.
            if ((cur_state == FILL) && (k >= int'(cur_y))) begin
                col_new[(WIN-2-k)*PIX_W +: PIX_W] = top_pix;
            end
`endif
        end
    end

    // Raster position, frame state and sticky framing error.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        y_inc   = cur_y + 1'b1;
        err_d   = err_q | drop;
        if (take) begin
            if (cur_x == X_LAST) begin
                x_d = '0;
                if (cur_y == Y_LAST) begin
                    y_d     = '0;
                    state_d = IDLE;
                end else begin
                    y_d     = y_inc;
                    state_d = (y_inc >= Y_STREAM) ? STREAM : FILL;
                end
            end else begin
                x_d     = cur_x + 1'b1;
                y_d     = cur_y;
                state_d = cur_state;
            end
        end
    end

    // Single output register; a new load wins over a same-cycle drain.
    always_comb begin
        vld_d = vld_q;
        col_d = col_q;
        sol_d = sol_q;
        eol_d = eol_q;
        eof_d = eof_q;
        if (load) begin
            vld_d = 1'b1;
            col_d = col_new;
            sol_d = (cur_x == '0);
            eol_d = (cur_x == X_LAST);
            eof_d = (cur_x == X_LAST) && (cur_y == Y_LAST);
        end else if (out_ready) begin
            vld_d = 1'b0;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            x_q      <= '0;
            y_q      <= '0;
            vld_q    <= 1'b0;
            col_q    <= '0;
            sol_q    <= 1'b0;
            eol_q    <= 1'b0;
            eof_q    <= 1'b0;
            err_q    <= 1'b0;
            rdy_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            vld_q    <= vld_d;
            col_q    <= col_d;
            sol_q    <= sol_d;
            eol_q    <= eol_d;
            eof_q    <= eof_d;
            err_q    <= err_d;
            rdy_en_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_window_column_feeder.sv
// Directed bench for window_column_feeder on an 8x10 image.
module tb_window_column_feeder;

    localparam int IMG_W = 8;
    localparam int IMG_H = 10;
    localparam int CW    = 56;
`ifdef WCF_BORDER_REPLICATE_EN
    localparam int COLS = 80;
    localparam int PART = 59;
    localparam int FIRST_IDX = 48;
`else
    localparam int COLS = 32;
    localparam int PART = 11;
    localparam int FIRST_IDX = 0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    in_pix;
    logic          in_valid;
    logic          in_sof;
    logic          in_ready;
    logic [CW-1:0] out_col;
    logic          out_valid;
    logic          out_ready;
    logic          out_sol;
    logic          out_eol;
    logic          out_eof;
    logic          frame_err;

    window_column_feeder #(
        .PIX_W (8),
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .WIN   (7)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_pix    (in_pix),
        .in_valid  (in_valid),
        .in_sof    (in_sof),
        .in_ready  (in_ready),
        .out_col   (out_col),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sol   (out_sol),
        .out_eol   (out_eol),
        .out_eof   (out_eof),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    int            total = 0;
    int            bad = 0;
    int            ncols;
    int            neof;
    logic          m_vld;
    logic [CW-1:0] got [$];
    logic [CW+2:0] exp_q [$];

    function automatic logic [7:0] pv(input int base, input int x, input int y);
        return 8'((base + 8 * y + x) & 255);
    endfunction

    // Column for (x,y): slice j holds row y-6+j.
    function automatic logic [CW-1:0] exp_col(input int base, input int x, input int y);
        logic [CW-1:0] c;
        int r;
        c = '0;
        for (int j = 0; j < 7; j++) begin
            r = y - 6 + j;
            if (r < 0) r = 0;
            c[j*8 +: 8] = pv(base, x, r);
        end
        return c;
    endfunction

    function automatic bit emits(input int y);
`ifdef WCF_BORDER_REPLICATE_EN
        return 1'b1;
`else
        return y >= 6;
`endif
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive, check at the falling edge, update the bench model.
    task automatic cyc(input logic v, input logic sof, input logic [7:0] pix, input logic ordy,
                       input bit emit, input logic [CW+2:0] ent, output bit acc);
        logic [CW+2:0] e;
        in_valid  = v;
        in_sof    = sof;
        in_pix    = pix;
        out_ready = ordy;
        @(negedge clk);
        chk("out_valid", 64'(out_valid), 64'(m_vld));
        chk("in_ready", 64'(in_ready), 64'(!m_vld || ordy));
        if (m_vld && ordy) begin
            if (exp_q.size() == 0) begin
                chk("queue_nonempty", 64'(exp_q.size()), 64'(1));
            end else begin
                e = exp_q.pop_front();
                chk("out_col", 64'(out_col), 64'(e[CW-1:0]));
                chk("out_sol", 64'(out_sol), 64'(e[CW]));
                chk("out_eol", 64'(out_eol), 64'(e[CW+1]));
                chk("out_eof", 64'(out_eof), 64'(e[CW+2]));
                got.push_back(out_col);
                ncols++;
                if (out_eof) neof++;
            end
        end
        acc = v && (!m_vld || ordy);
        if (acc && emit) begin
            exp_q.push_back(ent);
            m_vld = 1'b1;
        end else if (ordy) begin
            m_vld = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input int base, input int npix, input bit toggle);
        int i = 0;
        int guard = 0;
        bit tog = 1'b1;
        bit acc;
        int x, y;
        while (i < npix && guard < 4 * npix + 20) begin
            x = i % IMG_W;
            y = i / IMG_W;
            cyc(1'b1, i == 0, pv(base, x, y), toggle ? tog : 1'b1, emits(y),
                {(x == IMG_W - 1) && (y == IMG_H - 1), x == IMG_W - 1, x == 0,
                 exp_col(base, x, y)}, acc);
            tog = !tog;
            if (acc) i++;
            guard++;
        end
        chk("feed_count", 64'(i), 64'(npix));
    endtask

    task automatic drain();
        int g = 0;
        bit acc;
        while ((m_vld || exp_q.size() != 0) && g < 20) begin
            cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, '0, acc);
            g++;
        end
        chk("drain_empty", 64'(exp_q.size()), 64'(0));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(0));
        chk("rst_out_col", 64'(out_col), 64'(0));
        chk("rst_flags", 64'({out_sol, out_eol, out_eof}), 64'(0));
        chk("rst_frame_err", 64'(frame_err), 64'(0));
        in_valid  = 1'b0;
        in_sof    = 1'b0;
        out_ready = 1'b1;
        exp_q.delete();
        m_vld = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic new_test();
        ncols = 0;
        neof  = 0;
        got.delete();
    endtask

    initial begin
        bit acc;
        in_pix    = 8'h00;
        in_valid  = 1'b0;
        in_sof    = 1'b0;
        out_ready = 1'b1;
        rst       = 1'b0;
        m_vld     = 1'b0;
        #0;
        do_reset();

        // Continuous flow, full frame.
        new_test();
        feed(0, 80, 1'b0);
        drain();
        chk("cols_frame", 64'(ncols), 64'(COLS));
        chk("eof_count", 64'(neof), 64'(1));
        chk("first_stream_col", 64'(got[FIRST_IDX]), 64'(56'h30282018100800));
`ifdef WCF_BORDER_REPLICATE_EN
        chk("col_2_0", 64'(got[2]), 64'(56'h02020202020202));
        chk("col_2_1", 64'(got[10]), 64'(56'h0A020202020202));
`endif

        // Downstream ready toggling every cycle.
        new_test();
        feed(0, 80, 1'b1);
        drain();
        chk("cols_toggle", 64'(ncols), 64'(COLS));
        chk("eof_toggle", 64'(neof), 64'(1));

        // in_sof at (3,7) aborts and restarts with different data.
        new_test();
        feed(0, 59, 1'b0);
        feed(100, 80, 1'b0);
        drain();
        chk("cols_abort", 64'(ncols), 64'(PART + COLS));
        chk("eof_abort", 64'(neof), 64'(1));

        // Reset at (5,8) while the output is stalled.
        new_test();
        feed(0, 69, 1'b1);
        in_valid  = 1'b1;
        in_sof    = 1'b0;
        in_pix    = pv(0, 5, 8);
        out_ready = 1'b0;
        do_reset();
        new_test();
        feed(0, 80, 1'b0);
        drain();
        chk("cols_after_rst", 64'(ncols), 64'(COLS));

        // Pixels without in_sof after reset are dropped and flag an error.
        do_reset();
        new_test();
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 1'b0, 8'(i), 1'b1, 1'b0, '0, acc);
        end
        chk("frame_err_set", 64'(frame_err), 64'(1));
        chk("no_cols_idle", 64'(ncols), 64'(0));
        feed(0, 80, 1'b0);
        drain();
        chk("cols_after_err", 64'(ncols), 64'(COLS));
        chk("frame_err_sticky", 64'(frame_err), 64'(1));
        do_reset();
        chk("frame_err_clear", 64'(frame_err), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
